// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store bus master: DMType codes,
// FSM states and access-size helpers.
package lsu_pkg;

    localparam logic [2:0] DM_B  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b001;
    localparam logic [2:0] DM_W  = 3'b010;
    localparam logic [2:0] DM_BU = 3'b100;
    localparam logic [2:0] DM_HU = 3'b101;
    localparam logic [2:0] DM_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        ACC0,
        ACC1,
        DONE
    } state_t;

    // Access size in bytes: 1, 2 or 4.
    function automatic logic [2:0] size_of(input logic [2:0] dm_type);
        case (dm_type[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] lanemask(input logic [2:0] n);
        case (n)
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Codes x11 do not exist, and stores have no unsigned variants.
    function automatic logic is_illegal(input logic [2:0] dm_type, input logic we);
        return (dm_type[1:0] == 2'b11) || (we && dm_type[2]);
    endfunction

endpackage

// File: rtl/lsu_bus_master_if.sv
// Word-organised req/ack data memory bus with byte strobes.
interface lsu_bus_master_if;

    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Lane alignment datapath: shifts store data/strobes across a two-word window
// and extracts/extends load data from the captured {hi, lo} words.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  dm_type,
    input  logic [31:0] wdata,
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    output logic [7:0]  strb,
    output logic [63:0] lane_wdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        strb       = {4'b0000, lanemask(size_of(dm_type))} << off;
        lane_wdata = {32'b0, wdata} << {off, 3'b000};
        shifted    = 32'({hi, lo} >> {off, 3'b000});
        case (dm_type)
            DM_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            DM_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            DM_BU:   load_data = {24'b0, shifted[7:0]};
            DM_HU:   load_data = {16'b0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// MEM-stage load/store initiator: one request at a time, split into at most
// two word accesses, with pipeline stall, timeout and illegal-type reporting.
module lsu_bus_master
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic               req_we,
    input  logic [2:0]         req_type,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               stall,
    output logic               done,
    output logic               err,
    output logic [31:0]        rdata,
    lsu_bus_master_if.master   bus
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, wdata_q, lo_q, hi_q;
    logic [2:0]  type_q;
    logic        we_q, err_q;
    logic [15:0] cnt_q;
    logic        split, timeout;
    logic [7:0]  strb;
    logic [63:0] lane_wdata;
    logic [31:0] load_data;

    assign split = ({2'b00, addr_q[1:0]} + {1'b0, size_of(type_q)}) > 4'd4;

    lsu_align u_align (
        .off        (addr_q[1:0]),
        .dm_type    (type_q),
        .wdata      (wdata_q),
        .lo         (lo_q),
        .hi         (hi_q),
        .strb       (strb),
        .lane_wdata (lane_wdata),
        .load_data  (load_data)
    );

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_d       = state_q;
        timeout       = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wstrb = '0;
        bus.mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if (req_valid) state_d = is_illegal(req_type, req_we) ? DONE : ACC0;
            end
            ACC0: begin
                bus.mem_req  = 1'b1;
                bus.mem_we   = we_q;
                bus.mem_addr = addr_q[31:2];
                if (we_q) begin
                    bus.mem_wstrb = strb[3:0];
                    bus.mem_wdata = lane_wdata[31:0];
                end
                if (bus.mem_ack) begin
                    state_d = split ? ACC1 : DONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    timeout = 1'b1;
                    state_d = DONE;
                end
            end
            ACC1: begin
                bus.mem_req  = 1'b1;
                bus.mem_we   = we_q;
                bus.mem_addr = addr_q[31:2] + 30'd1;
                if (we_q) begin
                    bus.mem_wstrb = strb[7:4];
                    bus.mem_wdata = lane_wdata[63:32];
                end
                if (bus.mem_ack) begin
                    state_d = DONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    timeout = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall = (state_q == IDLE && req_valid) || state_q == ACC0 || state_q == ACC1;
        done  = (state_q == DONE);
        err   = done && err_q;
        rdata = (done && !err_q && !we_q) ? load_data : 32'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: datapath registers are reset as well, so an aborted access leaves no stale data behind.
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            type_q  <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            // The wait counter restarts on every state change, i.e. on each new bus access.
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (state_q == ACC0 || state_q == ACC1) begin
                cnt_q <= cnt_q + 16'd1;
            end
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        type_q  <= req_type;
                        we_q    <= req_we;
                        err_q   <= is_illegal(req_type, req_we);
                    end
                end
                ACC0: begin
                    if (bus.mem_ack) lo_q <= bus.mem_rdata;
                    else if (timeout) err_q <= 1'b1;
                end
                ACC1: begin
                    if (bus.mem_ack) hi_q <= bus.mem_rdata;
                    else if (timeout) err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/lsu_bus_master.md
Name: lsu_bus_master

Overview:
- Load/store initiator in the MEM stage of the RISC-V CPU, placed between pipeline control and a word-organised data memory port.
- Accepts one load/store per request using the DMType encoding of the data memory, and drives a req/ack word bus with byte strobes.
- Splits unaligned accesses that cross a word boundary into two bus transactions, then realigns and sign/zero-extends load data.
- Stalls the pipeline until the access completes, or until it errors or times out.

Parameters:
TIMEOUT_CYC, 255, cycles without mem_ack before a bus access is aborted with err (range 1..65535)

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  pipeline presents an access
req_we  in  1  1 = store, 0 = load
req_type  in  3  DMType: 000 b, 001 h, 010 w, 100 bu, 101 hu, 110 wu (= w)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
stall  out  1  pipeline hold
done  out  1  one-cycle completion pulse
err  out  1  valid with done: illegal type or timeout
rdata  out  32  extended load data, valid with done
mem_req  out  1  bus request
mem_we  out  1  bus write
mem_addr  out  30  word address (byte address [31:2])
mem_wstrb  out  4  byte-lane write enables
mem_wdata  out  32  lane-aligned write data
mem_ack  in  1  access accepted/completed this cycle; mem_rdata valid
mem_rdata  in  32  read word

Behaviour:
- Reset values (asynchronous, immediate): state IDLE; mem_req, mem_we, done, err = 0; mem_addr, mem_wstrb, mem_wdata, rdata = 0; timeout counter = 0. A reset mid-access drops mem_req in the same instant and discards captured data.
- FSM states: IDLE, ACC0, ACC1, DONE.
- IDLE, req_valid = 1:
  - Latch addr, type, we and wdata.
  - Size n = 1, 2 or 4 bytes; off = addr[1:0]; split = (off + n > 4).
  - Illegal type (011, 111, or a store with type[2] = 1): go to DONE with err = 1; no bus access.
  - Otherwise go to ACC0.
- stall = req_valid in IDLE, or state in {ACC0, ACC1}. stall is 0 in DONE.
- ACC0:
  - mem_req = 1; mem_addr = addr[31:2].
  - Stores: mem_wstrb = (lanemask(n) << off)[3:0]; mem_wdata = (wdata << 8*off)[31:0].
  - Loads: mem_wstrb = 0.
  - On mem_ack: capture mem_rdata as lo; go to ACC1 if split, else DONE.
- ACC1:
  - mem_addr = addr[31:2] + 1 (wraps modulo 2^30).
  - Stores: mem_wstrb = (lanemask << off)[7:4]; mem_wdata = (wdata << 8*off)[63:32].
  - On mem_ack: capture hi; go to DONE.
  - mem_req stays high from ACC0 into ACC1 (back-to-back accesses allowed).
- Bus rules:
  - Outputs stay stable while mem_req = 1 and mem_ack = 0.
  - mem_ack may be high in the first req cycle.
  - mem_ack while mem_req = 0 is ignored.
- Timeout:
  - The counter clears on entry to ACC0/ACC1 and increments each cycle without ack.
  - At count == TIMEOUT_CYC: drop mem_req, go to DONE with err = 1 and rdata = 0.
- DONE (1 cycle):
  - done = 1, mem_req = 0.
  - rdata = ({hi, lo} >> 8*off), truncated to n bytes: sign-extended for 000/001, zero-extended for 100/101; stores give rdata = 0.
  - Next state is IDLE. A request held during DONE is accepted in the following IDLE cycle.
- Latency: aligned access with immediate ack = 3 cycles (IDLE, ACC0, DONE); split access = 4 cycles.

Decomposition:
- Package lsu_pkg:
  - DMType constants (DM_B, DM_H, DM_W, DM_BU, DM_HU, DM_WU).
  - State enum.
  - Functions: size_of(type) and lanemask(n).
- One natural sub-module, lsu_align: combinational store-lane shifter plus load extract/extend over the 64-bit {hi, lo}. The FSM and counter stay in the top module.

Test Plan:
- sw addr 0x100, wdata 0xDEADBEEF, ack in first cycle -> one access: mem_addr 0x40, wstrb 1111, wdata 0xDEADBEEF; done at cycle 3; err 0.
- lb addr 0x203, memory word 0x80000000 -> wstrb 0000; rdata 0xFFFFFF80. The same access with lbu -> rdata 0x00000080.
- lw addr 0x102, words[0x40] = 0x11223344 and words[0x41] = 0x55667788 -> two accesses (0x40 then 0x41, req held high); rdata 0x77881122; done at cycle 4.
- sh addr 0x0FFF_FFFF, wdata 0xABCD:
  - First access: mem_addr 0x03FFFFFF, wstrb 1000, wdata 0xCD000000.
  - Second access: mem_addr 0x04000000, wstrb 0001, wdata 0x000000AB.
- Illegal and timeout cases:
  - Load type 011 -> no mem_req; done with err 1 one cycle later.
  - With TIMEOUT_CYC = 4 and mem_ack held 0 -> mem_req drops after 4 cycles; done with err 1; rdata 0.
- Assert rst during ACC1 with mem_ack held 0 -> mem_req, stall and done go to 0 immediately. After release, a new lw at 0x0 completes normally.
